// File: rtl/axi_addr_router_if.sv
// Address-routing bundle between the master-side slave port and the AXI address router.
// Covers both address channels, their response handshakes and the router's select/tracking outputs.
interface axi_addr_router_if #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned NUM_SLAVES      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
);
    localparam int unsigned TW = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic                  awvalid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awready;
    logic [NUM_SLAVES-1:0] aw_sel;
    logic                  aw_decerr;
    logic                  aw_stall;
    logic                  bvalid;
    logic                  bready;
    logic [TW-1:0]         wr_tgt;
    logic [CW-1:0]         wr_cnt;

    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic [NUM_SLAVES-1:0] ar_sel;
    logic                  ar_decerr;
    logic                  ar_stall;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [TW-1:0]         rd_tgt;
    logic [CW-1:0]         rd_cnt;

    modport slave (
        input  awvalid, awaddr, awready, bvalid, bready,
        input  arvalid, araddr, arready, rvalid, rready, rlast,
        output aw_sel, aw_decerr, aw_stall, wr_tgt, wr_cnt,
        output ar_sel, ar_decerr, ar_stall, rd_tgt, rd_cnt
    );

    modport master (
        output awvalid, awaddr, awready, bvalid, bready,
        output arvalid, araddr, arready, rvalid, rready, rlast,
        input  aw_sel, aw_decerr, aw_stall, wr_tgt, wr_cnt,
        input  ar_sel, ar_decerr, ar_stall, rd_tgt, rd_cnt
    );
endinterface

// File: rtl/axi_addr_router.sv
// AXI address router: decodes AW/AR addresses against a base/mask map into one-hot selects or DECERR,
// and tracks outstanding transactions per direction so a new target waits for older responses.
module axi_addr_router #(
    parameter int unsigned                      ADDR_WIDTH      = 32,
    parameter int unsigned                      NUM_SLAVES      = 2,
    parameter int unsigned                      MAX_OUTSTANDING = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE        = {32'h1000_0000, 32'h0},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK        = {32'hF000_0000, 32'hF000_0000}
) (
    input logic              clk,
    input logic              reset,
    axi_addr_router_if.slave bus
);
    localparam int unsigned TW = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StFull} state_e;

    // Lowest index wins because the scan runs downwards and overwrites.
    function automatic logic [TW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] mask;
        decode = TW'(NUM_SLAVES);
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            base = SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            mask = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((addr & mask) == (base & mask)) begin
                decode = TW'(i);
            end
        end
    endfunction

    // Index 0 is the write direction, index 1 the read direction.
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_done;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [NUM_SLAVES-1:0] sel      [2];
    logic [1:0]            decerr;
    logic [1:0]            stall;
    logic [TW-1:0]         tgt      [2];
    logic [CW-1:0]         cnt      [2];

    // Requests are masked while reset is held so no select leaks out during reset.
    assign req_valid   = {bus.arvalid, bus.awvalid} & {2{reset}};
    assign req_ready   = {bus.arready, bus.awready};
    assign rsp_done[0] = bus.bvalid & bus.bready;
    assign rsp_done[1] = bus.rvalid & bus.rready & bus.rlast;
    assign req_addr[0] = bus.awaddr;
    assign req_addr[1] = bus.araddr;

    for (genvar d = 0; d < 2; d++) begin : g_dir
        state_e                state_q, state_d;
        logic [CW-1:0]         cnt_q, cnt_d;
        logic [TW-1:0]         tgt_q, tgt_d;
        logic [TW-1:0]         dec_tgt;
        logic                  stall_c;
        logic                  accept;
        logic                  release_c;
        logic [NUM_SLAVES-1:0] sel_c;
        logic                  decerr_c;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            tgt_d    = tgt_q;
            stall_c  = 1'b0;
            sel_c    = '0;
            decerr_c = 1'b0;
            dec_tgt  = decode(req_addr[d]);

            unique case (state_q)
                StIdle:  stall_c = 1'b0;
                StBusy:  stall_c = req_valid[d] && (dec_tgt != tgt_q);
                StFull:  stall_c = req_valid[d];
                default: stall_c = req_valid[d];
            endcase

            if (req_valid[d] && !stall_c) begin
                if (dec_tgt < TW'(NUM_SLAVES)) begin
                    sel_c = NUM_SLAVES'(1) << dec_tgt;
                end else begin
                    decerr_c = 1'b1;
                end
            end

            accept    = req_valid[d] & ~stall_c & req_ready[d];
            release_c = rsp_done[d] & (cnt_q != '0);

            if (accept) begin
                tgt_d = dec_tgt;
            end
            if (accept && !release_c) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!accept && release_c) begin
                cnt_d = cnt_q - CW'(1);
            end

            if (cnt_d == '0) begin
                state_d = StIdle;
            end else if (cnt_d == CW'(MAX_OUTSTANDING)) begin
                state_d = StFull;
            end else begin
                state_d = StBusy;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                tgt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tgt_q   <= tgt_d;
            end
        end

        assign sel[d]    = sel_c;
        assign decerr[d] = decerr_c;
        assign stall[d]  = stall_c;
        assign tgt[d]    = tgt_q;
        assign cnt[d]    = cnt_q;
    end

    assign bus.aw_sel    = sel[0];
    assign bus.aw_decerr = decerr[0];
    assign bus.aw_stall  = stall[0];
    assign bus.wr_tgt    = tgt[0];
    assign bus.wr_cnt    = cnt[0];

    assign bus.ar_sel    = sel[1];
    assign bus.ar_decerr = decerr[1];
    assign bus.ar_stall  = stall[1];
    assign bus.rd_tgt    = tgt[1];
    assign bus.rd_cnt    = cnt[1];
endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: decode, stall/full behaviour, concurrent handshakes
// and asynchronous reset, with hand-computed expectations for the default two-slave map.
module tb_axi_addr_router;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    axi_addr_router_if #(
        .ADDR_WIDTH      (32),
        .NUM_SLAVES      (2),
        .MAX_OUTSTANDING (4)
    ) bus ();

    axi_addr_router dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        bus.arvalid = 1'b1; bus.araddr = 32'h2000_0000;
        #3;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_wr_cnt: got %0d expected 0", bus.wr_cnt); end
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_rd_cnt: got %0d expected 0", bus.rd_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd0) begin miscompares++; $display("FAIL rst_wr_tgt: got %0d expected 0", bus.wr_tgt); end
        vectors++; if (bus.rd_tgt !== 2'd0) begin miscompares++; $display("FAIL rst_rd_tgt: got %0d expected 0", bus.rd_tgt); end
        vectors++; if (bus.aw_sel !== 2'b00) begin miscompares++; $display("FAIL rst_aw_sel: got %b expected 00", bus.aw_sel); end
        vectors++; if (bus.ar_decerr !== 1'b0) begin miscompares++; $display("FAIL rst_ar_decerr: got %b expected 0", bus.ar_decerr); end
        vectors++; if (bus.aw_stall !== 1'b0) begin miscompares++; $display("FAIL rst_aw_stall: got %b expected 0", bus.aw_stall); end
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_decode();
        bus.awvalid = 1'b1; bus.awaddr = 32'h0000_1000; bus.awready = 1'b1;
        #1;
        vectors++; if (bus.aw_sel !== 2'b01) begin miscompares++; $display("FAIL wd_aw_sel: got %b expected 01", bus.aw_sel); end
        vectors++; if (bus.aw_decerr !== 1'b0) begin miscompares++; $display("FAIL wd_aw_decerr: got %b expected 0", bus.aw_decerr); end
        vectors++; if (bus.aw_stall !== 1'b0) begin miscompares++; $display("FAIL wd_aw_stall: got %b expected 0", bus.aw_stall); end
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd1) begin miscompares++; $display("FAIL wd_wr_cnt: got %0d expected 1", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd0) begin miscompares++; $display("FAIL wd_wr_tgt: got %0d expected 0", bus.wr_tgt); end
        bus.bvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL wd_drain_cnt: got %0d expected 0", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd0) begin miscompares++; $display("FAIL wd_tgt_kept: got %0d expected 0", bus.wr_tgt); end
    endtask

    task automatic test_read_decode();
        bus.arvalid = 1'b1; bus.araddr = 32'h1000_0040; bus.arready = 1'b1;
        #1;
        vectors++; if (bus.ar_sel !== 2'b10) begin miscompares++; $display("FAIL rd_ar_sel: got %b expected 10", bus.ar_sel); end
        vectors++; if (bus.ar_decerr !== 1'b0) begin miscompares++; $display("FAIL rd_ar_decerr: got %b expected 0", bus.ar_decerr); end
        tick();
        bus.arvalid = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd1) begin miscompares++; $display("FAIL rd_cnt1: got %0d expected 1", bus.rd_cnt); end
        vectors++; if (bus.rd_tgt !== 2'd1) begin miscompares++; $display("FAIL rd_tgt1: got %0d expected 1", bus.rd_tgt); end
        bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
        tick();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL rd_cnt_drain: got %0d expected 0", bus.rd_cnt); end
        bus.arvalid = 1'b1; bus.araddr = 32'h2000_0000;
        #1;
        vectors++; if (bus.ar_decerr !== 1'b1) begin miscompares++; $display("FAIL rd_decerr: got %b expected 1", bus.ar_decerr); end
        vectors++; if (bus.ar_sel !== 2'b00) begin miscompares++; $display("FAIL rd_decerr_sel: got %b expected 00", bus.ar_sel); end
        tick();
        vectors++; if (bus.rd_tgt !== 2'd2) begin miscompares++; $display("FAIL rd_tgt_decerr: got %0d expected 2", bus.rd_tgt); end
        vectors++; if (bus.rd_cnt !== 3'd1) begin miscompares++; $display("FAIL rd_cnt_decerr: got %0d expected 1", bus.rd_cnt); end
        // All-ones address decodes to DECERR too, matching the in-flight target, so no stall.
        bus.araddr = 32'hFFFF_FFFF; bus.arready = 1'b0;
        #1;
        vectors++; if (bus.ar_decerr !== 1'b1) begin miscompares++; $display("FAIL rd_ffff_decerr: got %b expected 1", bus.ar_decerr); end
        vectors++; if (bus.ar_stall !== 1'b0) begin miscompares++; $display("FAIL rd_ffff_stall: got %b expected 0", bus.ar_stall); end
        tick();
        bus.araddr = 32'h0;
        #1;
        vectors++; if (bus.ar_stall !== 1'b1) begin miscompares++; $display("FAIL rd_switch_stall: got %b expected 1", bus.ar_stall); end
        vectors++; if (bus.ar_sel !== 2'b00) begin miscompares++; $display("FAIL rd_switch_sel: got %b expected 00", bus.ar_sel); end
        bus.arvalid = 1'b0; bus.arready = 1'b1;
        bus.rvalid = 1'b1; bus.rlast = 1'b1;
        tick();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL rd_cnt_end: got %0d expected 0", bus.rd_cnt); end
    endtask

    task automatic test_full();
        bus.awvalid = 1'b1; bus.awaddr = 32'h1000_0000; bus.awready = 1'b1;
        repeat (4) tick();
        vectors++; if (bus.wr_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt: got %0d expected 4", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd1) begin miscompares++; $display("FAIL full_tgt: got %0d expected 1", bus.wr_tgt); end
        vectors++; if (bus.aw_stall !== 1'b1) begin miscompares++; $display("FAIL full_stall: got %b expected 1", bus.aw_stall); end
        vectors++; if (bus.aw_sel !== 2'b00) begin miscompares++; $display("FAIL full_sel: got %b expected 00", bus.aw_sel); end
        tick();
        vectors++; if (bus.wr_cnt !== 3'd4) begin miscompares++; $display("FAIL full_hold_cnt: got %0d expected 4", bus.wr_cnt); end
        bus.bvalid = 1'b1; bus.bready = 1'b1;
        #1;
        vectors++; if (bus.aw_stall !== 1'b1) begin miscompares++; $display("FAIL full_b_stall: got %b expected 1", bus.aw_stall); end
        tick();
        bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd3) begin miscompares++; $display("FAIL full_after_b: got %0d expected 3", bus.wr_cnt); end
        vectors++; if (bus.aw_stall !== 1'b0) begin miscompares++; $display("FAIL full_unstall: got %b expected 0", bus.aw_stall); end
        vectors++; if (bus.aw_sel !== 2'b10) begin miscompares++; $display("FAIL full_5th_sel: got %b expected 10", bus.aw_sel); end
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd4) begin miscompares++; $display("FAIL full_5th_cnt: got %0d expected 4", bus.wr_cnt); end
        bus.bvalid = 1'b1;
        repeat (4) tick();
        bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d expected 0", bus.wr_cnt); end
    endtask

    task automatic test_target_switch();
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd1) begin miscompares++; $display("FAIL sw_cnt: got %0d expected 1", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd0) begin miscompares++; $display("FAIL sw_tgt0: got %0d expected 0", bus.wr_tgt); end
        bus.awvalid = 1'b1; bus.awaddr = 32'h1000_0000;
        #1;
        vectors++; if (bus.aw_stall !== 1'b1) begin miscompares++; $display("FAIL sw_stall: got %b expected 1", bus.aw_stall); end
        vectors++; if (bus.aw_sel !== 2'b00) begin miscompares++; $display("FAIL sw_sel_stalled: got %b expected 00", bus.aw_sel); end
        tick();
        vectors++; if (bus.wr_cnt !== 3'd1) begin miscompares++; $display("FAIL sw_cnt_held: got %0d expected 1", bus.wr_cnt); end
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL sw_cnt_drained: got %0d expected 0", bus.wr_cnt); end
        vectors++; if (bus.aw_sel !== 2'b10) begin miscompares++; $display("FAIL sw_sel: got %b expected 10", bus.aw_sel); end
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd1) begin miscompares++; $display("FAIL sw_cnt_new: got %0d expected 1", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd1) begin miscompares++; $display("FAIL sw_tgt1: got %0d expected 1", bus.wr_tgt); end
    endtask

    task automatic test_simultaneous();
        bus.awvalid = 1'b1; bus.awaddr = 32'h1000_0000;
        tick();
        vectors++; if (bus.wr_cnt !== 3'd2) begin miscompares++; $display("FAIL sim_cnt2: got %0d expected 2", bus.wr_cnt); end
        bus.bvalid = 1'b1;
        #1;
        vectors++; if (bus.aw_stall !== 1'b0) begin miscompares++; $display("FAIL sim_stall: got %b expected 0", bus.aw_stall); end
        tick();
        bus.awvalid = 1'b0; bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd2) begin miscompares++; $display("FAIL sim_cnt_same: got %0d expected 2", bus.wr_cnt); end
        vectors++; if (bus.wr_tgt !== 2'd1) begin miscompares++; $display("FAIL sim_tgt: got %0d expected 1", bus.wr_tgt); end
        bus.arvalid = 1'b1; bus.araddr = 32'h0000_0040;
        #1;
        vectors++; if (bus.ar_sel !== 2'b01) begin miscompares++; $display("FAIL sim_ar_sel: got %b expected 01", bus.ar_sel); end
        tick();
        bus.arvalid = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd1) begin miscompares++; $display("FAIL sim_rd_cnt: got %0d expected 1", bus.rd_cnt); end
        vectors++; if (bus.rd_tgt !== 2'd0) begin miscompares++; $display("FAIL sim_rd_tgt: got %0d expected 0", bus.rd_tgt); end
        bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.rd_cnt !== 3'd1) begin miscompares++; $display("FAIL sim_nonlast: got %0d expected 1", bus.rd_cnt); end
        bus.rlast = 1'b1;
        tick();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL sim_last: got %0d expected 0", bus.rd_cnt); end
        bus.bvalid = 1'b1;
        repeat (2) tick();
        bus.bvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL sim_wr_drain: got %0d expected 0", bus.wr_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        bus.arvalid = 1'b1; bus.araddr = 32'h1000_0000;
        #1;
        vectors++; if (bus.aw_sel !== 2'b01) begin miscompares++; $display("FAIL b2b_aw_sel: got %b expected 01", bus.aw_sel); end
        vectors++; if (bus.ar_sel !== 2'b10) begin miscompares++; $display("FAIL b2b_ar_sel: got %b expected 10", bus.ar_sel); end
        tick();
        vectors++; if (bus.wr_tgt !== 2'd0) begin miscompares++; $display("FAIL b2b_wr_tgt: got %0d expected 0", bus.wr_tgt); end
        vectors++; if (bus.rd_tgt !== 2'd1) begin miscompares++; $display("FAIL b2b_rd_tgt: got %0d expected 1", bus.rd_tgt); end
        tick();
        bus.arvalid = 1'b0;
        vectors++; if (bus.rd_cnt !== 3'd2) begin miscompares++; $display("FAIL b2b_rd_cnt: got %0d expected 2", bus.rd_cnt); end
        vectors++; if (bus.wr_cnt !== 3'd2) begin miscompares++; $display("FAIL b2b_wr_cnt2: got %0d expected 2", bus.wr_cnt); end
        tick();
        bus.awvalid = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd3) begin miscompares++; $display("FAIL b2b_wr_cnt3: got %0d expected 3", bus.wr_cnt); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 32'h0;
        #1;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL ar_wr_cnt: got %0d expected 0", bus.wr_cnt); end
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL ar_rd_cnt: got %0d expected 0", bus.rd_cnt); end
        vectors++; if (bus.rd_tgt !== 2'd0) begin miscompares++; $display("FAIL ar_rd_tgt: got %0d expected 0", bus.rd_tgt); end
        vectors++; if (bus.aw_sel !== 2'b00) begin miscompares++; $display("FAIL ar_aw_sel: got %b expected 00", bus.aw_sel); end
        bus.awvalid = 1'b0;
        #2;
        reset = 1'b1;
        bus.bvalid = 1'b1; bus.bready = 1'b1;
        bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
        repeat (2) tick();
        bus.bvalid = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
        vectors++; if (bus.wr_cnt !== 3'd0) begin miscompares++; $display("FAIL ar_stray_b: got %0d expected 0", bus.wr_cnt); end
        vectors++; if (bus.rd_cnt !== 3'd0) begin miscompares++; $display("FAIL ar_stray_r: got %0d expected 0", bus.rd_cnt); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awready = 1'b0;
        bus.bvalid  = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arready = 1'b0;
        bus.rvalid  = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;

        test_reset();
        test_write_decode();
        test_read_decode();
        test_full();
        test_target_switch();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
